alu: RTL and testbench



---
 rtl/rv_pkg.sv | 41 ++++
 rtl/alu_decode.sv | 43 ++++
 rtl/alu.sv | 63 ++++++
 tb/tb_alu.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV64I encoding constants and the ALU operation enum.
// Both the decoder and the execute-stage datapath import this package.
package rv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [6:0] OPCODE_OP = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ADD,
    SUB,
    SLL,
    SRL,
    SRA,
    SLT,
    SLTU,
    XOR,
    OR,
    AND,
    ILLEGAL
  } alu_op_t;

  // Only the low six bits of rs2 select the shift distance on RV64.
  function automatic logic [5:0] shamt(input logic [XLEN-1:0] val);
    return val[5:0];
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational R-type decoder: instruction word to alu_op_t.
// Anything that is not a supported OP-opcode encoding decodes to ILLEGAL.
module alu_decode
  import rv_pkg::*;
(
  input  logic [ILEN-1:0] instruction,
  output alu_op_t         op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_base;
  logic       is_alt;
  logic       unused_reg_fields;

  assign opcode  = instruction[6:0];
  assign funct3  = instruction[14:12];
  assign funct7  = instruction[31:25];
  assign is_base = (funct7 == F7_BASE);
  assign is_alt  = (funct7 == F7_ALT);

  // rd, rs1 and rs2 select registers upstream; they do not affect the op.
  assign unused_reg_fields = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    op = ILLEGAL;
    if (opcode == OPCODE_OP && (is_base || is_alt)) begin
      case (funct3)
        F3_ADD_SUB: op = is_alt ? SUB : ADD;
        F3_SRL_SRA: op = is_alt ? SRA : SRL;
        F3_SLL:     op = is_base ? SLL  : ILLEGAL;
        F3_SLT:     op = is_base ? SLT  : ILLEGAL;
        F3_SLTU:    op = is_base ? SLTU : ILLEGAL;
        F3_XOR:     op = is_base ? XOR  : ILLEGAL;
        F3_OR:      op = is_base ? OR   : ILLEGAL;
        F3_AND:     op = is_base ? AND  : ILLEGAL;
        default:    op = ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/alu.sv
// Registered 64-bit RV64I execute-stage ALU: decode, datapath mux and a
// single output register, so each result appears exactly one clock later.
module alu
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] out,
  output logic            illegal
);

  alu_op_t         op;
  logic [5:0]      sh;
  logic            lt_signed;
  logic            lt_unsigned;
  logic [XLEN-1:0] out_d, out_q;
  logic            illegal_d, illegal_q;

  alu_decode u_decode (
    .instruction (instruction),
    .op          (op)
  );

  assign sh          = shamt(b);
  assign lt_signed   = ($signed(a) < $signed(b));
  assign lt_unsigned = (a < b);

  always_comb begin
    out_d     = '0;
    illegal_d = 1'b0;
    case (op)
      ADD:     out_d = a + b;
      SUB:     out_d = a - b;
      SLL:     out_d = a << sh;
      SRL:     out_d = a >> sh;
      SRA:     out_d = $unsigned($signed(a) >>> sh);
      SLT:     out_d = {{(XLEN-1){1'b0}}, lt_signed};
      SLTU:    out_d = {{(XLEN-1){1'b0}}, lt_unsigned};
      XOR:     out_d = a ^ b;
      OR:      out_d = a | b;
      AND:     out_d = a & b;
      default: illegal_d = 1'b1;
    endcase
  end

  // Reset drops any in-flight result; both outputs read zero while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      illegal_q <= illegal_d;
    end
  end

  assign out     = out_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: expected results are queued as each op is
// driven and compared once the output register has captured it.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic [31:0] instruction;
  logic [63:0] out;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_out_q[$];
  logic        exp_ill_q[$];
  string       tag_q[$];

  alu u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .instruction (instruction),
    .out         (out),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc);
    return {f7, 5'd6, 5'd5, f3, 5'd7, opc};
  endfunction

  // Drive on the falling edge, let the rising edge capture, compare just after.
  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                        input logic [31:0] instr, input logic [63:0] e_out, input logic e_ill);
    @(negedge clk);
    a           = av;
    b           = bv;
    instruction = instr;
    exp_out_q.push_back(e_out);
    exp_ill_q.push_back(e_ill);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_out_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      string t;
      t = tag_q.pop_front();
      check({t, "_out"}, out, exp_out_q.pop_front());
      check({t, "_ill"}, {63'd0, illegal}, {63'd0, exp_ill_q.pop_front()});
    end
  endtask

  localparam logic [6:0] OPC = 7'b0110011;
  localparam logic [6:0] B7  = 7'b0000000;
  localparam logic [6:0] A7  = 7'b0100000;

  initial begin
    logic [63:0] held;
    rst_n       = 1'b0;
    a           = '0;
    b           = '0;
    instruction = 32'h006283B3;
    #12;
    check("rst_out", out, 64'd0);
    check("rst_ill", {63'd0, illegal}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add",  64'd4294967296, 64'd8, 32'h006283B3, 64'd4294967304, 1'b0);
    run_op("sub",  64'd4294967296, 64'd8, 32'h406283B3, 64'd4294967288, 1'b0);
    run_op("sll",  64'h0000000100000000, 64'd8, enc(B7, 3'b001, OPC), 64'h0000010000000000, 1'b0);
    run_op("srl",  64'h0000000100000000, 64'd8, enc(B7, 3'b101, OPC), 64'h0000000001000000, 1'b0);
    run_op("sra",  64'h8000000000000000, 64'd4, enc(A7, 3'b101, OPC), 64'hF800000000000000, 1'b0);
    run_op("srl_neg", 64'h8000000000000000, 64'd4, enc(B7, 3'b101, OPC), 64'h0800000000000000, 1'b0);
    run_op("sll_b48", 64'h0000000100000000, 64'h48, enc(B7, 3'b001, OPC), 64'h0000010000000000, 1'b0);
    run_op("sll_63", 64'd1, 64'hFFFFFFFFFFFFFFFF, enc(B7, 3'b001, OPC), 64'h8000000000000000, 1'b0);
    run_op("slt0", 64'd4294967296, 64'd8, enc(B7, 3'b010, OPC), 64'd0, 1'b0);
    run_op("slt1", 64'hFFFFFFFFFFFFFFFF, 64'd1, enc(B7, 3'b010, OPC), 64'd1, 1'b0);
    run_op("sltu", 64'hFFFFFFFFFFFFFFFF, 64'd1, enc(B7, 3'b011, OPC), 64'd0, 1'b0);
    run_op("sltu1", 64'd1, 64'hFFFFFFFFFFFFFFFF, enc(B7, 3'b011, OPC), 64'd1, 1'b0);
    run_op("or",   64'h0000000100000000, 64'd8, enc(B7, 3'b110, OPC), 64'h0000000100000008, 1'b0);
    run_op("and",  64'h0000000100000000, 64'd8, enc(B7, 3'b111, OPC), 64'd0, 1'b0);
    run_op("xor",  64'h0000000100000000, 64'd8, enc(B7, 3'b100, OPC), 64'h0000000100000008, 1'b0);
    run_op("add_wrap", 64'hFFFFFFFFFFFFFFFF, 64'd2, 32'h006283B3, 64'd1, 1'b0);
    run_op("ill_opc", 64'd5, 64'd8, enc(B7, 3'b000, 7'b0010011), 64'd0, 1'b1);
    run_op("ill_f7and", 64'd5, 64'd8, enc(A7, 3'b111, OPC), 64'd0, 1'b1);
    run_op("ill_f7sll", 64'd5, 64'd8, enc(A7, 3'b001, OPC), 64'd0, 1'b1);
    run_op("ill_mul", 64'd5, 64'd8, enc(7'b0000001, 3'b000, OPC), 64'd0, 1'b1);
    run_op("clear_ill", 64'd5, 64'd8, 32'h006283B3, 64'd13, 1'b0);

    // Inputs wiggling between edges must not reach the outputs.
    a           = 64'd1000;
    instruction = 32'h406283B3;
    #2;
    check("hold_out", out, 64'd13);
    check("hold_ill", {63'd0, illegal}, 64'd0);

    run_op("pre_rst", 64'd40, 64'd2, 32'h006283B3, 64'd42, 1'b0);
    held = out;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 64'd0);
    check("async_rst_ill", {63'd0, illegal}, 64'd0);
    a           = 64'd7;
    b           = 64'd7;
    instruction = 32'h006283B3;
    @(posedge clk);
    #1;
    check("rst_hold_out", out, 64'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rel_out", out, 64'd0);
    @(posedge clk);
    #1;
    check("first_cap", out, 64'd14);
    check("held_nz", {63'd0, held != 64'd0}, 64'd1);

    if (exp_out_q.size() != 0) check("queue_empty", 64'(exp_out_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
